// File: rtl/sum_frame_accumulator.sv
// sum_frame_accumulator
//
// Groups the width-bit sum stream into frames of `count` items and reduces each
// frame to one out_width-bit total with a sticky overflow flag. Accumulation of
// the next frame continues while the previous total waits downstream. Input is
// stalled only when a frame's last item arrives while the output register is
// still full and is not being drained in that cycle.
//
// Optional feature: define SUM_FRAME_ACCUMULATOR_SATURATE_EN to clamp the
// accumulator and the total to all-ones on overflow. When it is undefined
// (default build), sums wrap modulo 2^out_width and the overflow flag is still set.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-low reset
//   up_valid      incoming sum valid
//   up_ready      block accepts incoming sum (combinational from down_ready)
//   up_data       incoming sum, unsigned, width bits
//   down_valid    frame total valid (registered)
//   down_ready    downstream accepts total
//   down_data     frame total, unsigned, out_width bits
//   down_overflow frame total exceeded out_width bits; qualified by down_valid

module sum_frame_accumulator #(
  parameter int unsigned width     = 8,
  parameter int unsigned count     = 4,
  parameter int unsigned out_width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [width-1:0]     up_data,
  output logic                 down_valid,
  input  logic                 down_ready,
  output logic [out_width-1:0] down_data,
  output logic                 down_overflow
);

  // A one-item frame still needs a one-bit counter that simply stays at zero.
  localparam int unsigned CntW = (count > 1) ? $clog2(count) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(count - 1);

  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [out_width-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [out_width-1:0] data_q, data_d;
  logic                 dovf_q, dovf_d;
  logic                 dvalid_q, dvalid_d;

  logic                 last;
  logic                 up_fire;
  logic                 down_fire;
  logic [out_width:0]   sum;
  logic                 carry;
  logic [out_width-1:0] acc_next;

  assign last      = (cnt_q == CntLast);
  assign up_ready  = rst & ~(dvalid_q & ~down_ready & last);
  assign up_fire   = up_valid & up_ready;
  assign down_fire = dvalid_q & down_ready;

  // Zero-extend both operands to out_width+1 so the top bit is the carry.
  assign sum   = {1'b0, acc_q} + {{(out_width + 1 - width){1'b0}}, up_data};
  assign carry = sum[out_width];

  always_comb begin
    acc_next = sum[out_width-1:0];
`ifdef SUM_FRAME_ACCUMULATOR_SATURATE_EN
    // Once clamped, any nonzero addition carries again, so the value stays clamped.
    if (carry) begin
      acc_next = '1;
    end
`endif
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    data_d   = data_q;
    dovf_d   = dovf_q;
    dvalid_d = dvalid_q;

    // Draining first lets a same-cycle last item reload the register below.
    if (down_fire) begin
      dvalid_d = 1'b0;
    end

    if (up_fire) begin
      if (last) begin
        data_d   = acc_next;
        dovf_d   = ovf_q | carry;
        dvalid_d = 1'b1;
        acc_d    = '0;
        ovf_d    = 1'b0;
        cnt_d    = '0;
      end else begin
        acc_d    = acc_next;
        ovf_d    = ovf_q | carry;
        cnt_d    = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      data_q   <= '0;
      dovf_q   <= 1'b0;
      dvalid_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      data_q   <= data_d;
      dovf_q   <= dovf_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign down_valid    = dvalid_q;
  assign down_data     = data_q;
  assign down_overflow = dovf_q;

endmodule
